// File: rtl/rf_writeback_pkg.sv
// Shared widths and the writeback entry record {addr, data}, reused by the
// register file bypass logic.
package rf_writeback_pkg;

   localparam int unsigned RF_ADDR_WIDTH = 5;
   localparam int unsigned DATA_WIDTH    = 32;

   typedef struct packed {
      logic [RF_ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// 2-in/2-out circular buffer of writeback entries.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (pointers/count only)
//   enq_cnt           number of entries pushed this cycle (0..2)
//   enq_0, enq_1      pushed entries, enq_0 is older and lands at tail
//   deq_cnt           number of entries popped this cycle (0..2)
//   head_0, head_1    entries at head and head+1
//   count             number of valid entries
//   valid, addrs      per-slot valid flag and destination address
module wb_fifo2
   import rf_writeback_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [1:0]                          enq_cnt,
   input  wb_entry_t                           enq_0,
   input  wb_entry_t                           enq_1,
   input  logic [1:0]                          deq_cnt,
   output wb_entry_t                           head_0,
   output wb_entry_t                           head_1,
   output logic [$clog2(DEPTH+1)-1:0]          count,
   output logic [DEPTH-1:0]                    valid,
   output logic [DEPTH-1:0][RF_ADDR_WIDTH-1:0] addrs
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   wb_entry_t     mem [DEPTH];

   // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(deq_cnt);
         tail  <= tail + PW'(enq_cnt);
         count <= count + CW'(enq_cnt) - CW'(deq_cnt);
      end
   end

   // Entry storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (enq_cnt != 2'd0) mem[tail] <= enq_0;
      if (enq_cnt == 2'd2) mem[tail + PW'(1)] <= enq_1;
   end

   assign head_0 = mem[head];
   assign head_1 = mem[head + PW'(1)];

   // A slot is valid when its distance from head is below count
   always_comb begin
      valid = '0;
      addrs = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         valid[i] = CW'(PW'(i) - head) < count;
         addrs[i] = mem[i].addr;
      end
   end

endmodule

// File: rtl/rf_writeback.sv
// Dual-lane writeback buffer between execute/memory and the two register
// file write ports. Drops x0 writes, never writes one register twice in a
// cycle, and reports in-flight destinations for issue stalls.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   inValid_x/inAddr_x/inData_x   incoming results, lane 0 older than lane 1
//   inReady                       both lanes may be presented this cycle
//   wEN_x/wAddr_x/wData_x         register file write ports
//   qAddr_x / qBusy_x             hazard query: register has a queued write
//   empty                         no entries queued
module rf_writeback
   import rf_writeback_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     inValid_0,
   input  logic [RF_ADDR_WIDTH-1:0] inAddr_0,
   input  logic [DATA_WIDTH-1:0]    inData_0,
   input  logic                     inValid_1,
   input  logic [RF_ADDR_WIDTH-1:0] inAddr_1,
   input  logic [DATA_WIDTH-1:0]    inData_1,
   output logic                     inReady,
   output logic                     wEN_0,
   output logic [RF_ADDR_WIDTH-1:0] wAddr_0,
   output logic [DATA_WIDTH-1:0]    wData_0,
   output logic                     wEN_1,
   output logic [RF_ADDR_WIDTH-1:0] wAddr_1,
   output logic [DATA_WIDTH-1:0]    wData_1,
   input  logic [RF_ADDR_WIDTH-1:0] qAddr_0,
   input  logic [RF_ADDR_WIDTH-1:0] qAddr_1,
   output logic                     qBusy_0,
   output logic                     qBusy_1,
   output logic                     empty
);

   localparam int unsigned CW = $clog2(DEPTH+1);

   wb_entry_t                           lane_0;
   wb_entry_t                           lane_1;
   wb_entry_t                           enq_0;
   wb_entry_t                           head_0;
   wb_entry_t                           head_1;
   logic [1:0]                          enq_cnt;
   logic [1:0]                          deq_cnt;
   logic                                keep_0;
   logic                                keep_1;
   logic [CW-1:0]                       count;
   logic [DEPTH-1:0]                    valid;
   logic [DEPTH-1:0][RF_ADDR_WIDTH-1:0] addrs;

   // Conservative ready: room for two entries regardless of how many lanes fire
   assign inReady = rst_n & (count <= CW'(DEPTH - 2));

   // x0 results are consumed but never queued
   assign keep_0 = inValid_0 & inReady & (inAddr_0 != '0);
   assign keep_1 = inValid_1 & inReady & (inAddr_1 != '0);

   assign lane_0  = '{addr: inAddr_0, data: inData_0};
   assign lane_1  = '{addr: inAddr_1, data: inData_1};
   assign enq_cnt = {1'b0, keep_0} + {1'b0, keep_1};
   // Compact survivors so the older one always lands at tail
   assign enq_0   = keep_0 ? lane_0 : lane_1;

   // Same-address pair retires one per cycle so the younger value lands last
   assign wEN_0   = rst_n & (count != '0);
   assign wEN_1   = rst_n & (count >= CW'(2)) & (head_1.addr != head_0.addr);
   assign wAddr_0 = head_0.addr;
   assign wData_0 = head_0.data;
   assign wAddr_1 = head_1.addr;
   assign wData_1 = head_1.data;
   assign deq_cnt = {1'b0, wEN_0} + {1'b0, wEN_1};

   assign empty   = ~rst_n | (count == '0);

   // Hazard compare over all valid entries, including those retiring now
   always_comb begin
      qBusy_0 = 1'b0;
      qBusy_1 = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid[i] && addrs[i] == qAddr_0) qBusy_0 = 1'b1;
         if (valid[i] && addrs[i] == qAddr_1) qBusy_1 = 1'b1;
      end
      if (!rst_n || qAddr_0 == '0) qBusy_0 = 1'b0;
      if (!rst_n || qAddr_1 == '0) qBusy_1 = 1'b0;
   end

   wb_fifo2 #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .enq_cnt (enq_cnt),
      .enq_0   (enq_0),
      .enq_1   (lane_1),
      .deq_cnt (deq_cnt),
      .head_0  (head_0),
      .head_1  (head_1),
      .count   (count),
      .valid   (valid),
      .addrs   (addrs)
   );

endmodule
